// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths, frame size and the result-streamer state encoding.
package npu_pkg;

   localparam int RESULT_W    = 18;
   localparam int PIXEL_W     = 8;
   localparam int NUM_RESULTS = 30;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } stream_state_t;

endpackage

// File: rtl/conv_result_streamer_if.sv
// Valid/ready element stream leaving the result streamer toward the next NPU stage.
interface conv_result_streamer_if #(
   parameter int OUT_W = npu_pkg::PIXEL_W,
   parameter int IDX_W = $clog2(npu_pkg::NUM_RESULTS)
) ();

   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic [IDX_W-1:0]        out_index;
   logic                    out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/requant_unit.sv
// Combinational requantiser: arithmetic right shift, optional ReLU, saturate to OUT_W bits.
module requant_unit #(
   parameter int IN_W  = npu_pkg::RESULT_W,
   parameter int OUT_W = npu_pkg::PIXEL_W,
   parameter int SHIFT = 2
) (
   input  logic signed [IN_W-1:0]  din,
   input  logic                    relu_en,
   output logic signed [OUT_W-1:0] dout,
   output logic                    sat
);

   // Output range expressed at the input width so the comparisons stay signed and exact.
   localparam logic signed [IN_W-1:0] MAX_V = $signed({{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [IN_W-1:0] MIN_V = $signed({{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

   logic signed [IN_W-1:0] shifted;
   logic signed [IN_W-1:0] rectified;

   always_comb begin
      shifted   = din >>> SHIFT;
      rectified = (relu_en && (shifted < 0)) ? '0 : shifted;
      sat       = 1'b0;
      dout      = rectified[OUT_W-1:0];
      if (rectified > MAX_V) begin
         sat  = 1'b1;
         dout = MAX_V[OUT_W-1:0];
      end else if (rectified < MIN_V) begin
         sat  = 1'b1;
         dout = MIN_V[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a conv-engine result frame on done_signal and streams it out requantised,
// one element per accepted handshake, with saturation counting and lost-frame detection.
module conv_result_streamer #(
   parameter int NUM_RESULTS = npu_pkg::NUM_RESULTS,
   parameter int IN_W        = npu_pkg::RESULT_W,
   parameter int OUT_W       = npu_pkg::PIXEL_W,
   parameter int SHIFT       = 2,
   localparam int IDX_W      = $clog2(NUM_RESULTS),
   localparam int SAT_W      = $clog2(NUM_RESULTS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   done_signal,
   input  logic signed [IN_W-1:0] result_data [0:NUM_RESULTS-1],
   input  logic                   relu_en,
   output logic                   busy,
   output logic [SAT_W-1:0]       sat_count,
   output logic                   drop_err,
   conv_result_streamer_if.master out_if
);

   import npu_pkg::*;

   stream_state_t           state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic                    out_last_q, out_last_d;
   logic                    out_sat_q, out_sat_d;
   logic                    relu_q, relu_d;
   logic [SAT_W-1:0]        sat_q, sat_d;
   logic                    drop_q, drop_d;

   logic signed [IN_W-1:0]  buf_q [0:NUM_RESULTS-1];
   logic signed [IN_W-1:0]  buf_d [0:NUM_RESULTS-1];

   logic                    xfer;
   logic                    last_xfer;
   logic                    capture;
   logic [IDX_W-1:0]        nxt_idx;
   logic signed [IN_W-1:0]  rq_din;
   logic                    rq_relu;
   logic signed [OUT_W-1:0] rq_dout;
   logic                    rq_sat;

   assign xfer      = out_valid_q && out_if.out_ready;
   assign last_xfer = xfer && out_last_q;
   // A new frame is accepted when idle, or exactly on the cycle the current frame finishes.
   assign capture   = done_signal && ((state_q == ST_IDLE) || last_xfer);
   assign nxt_idx   = out_last_q ? '0 : idx_q + IDX_W'(1);

   // The requantiser always prepares the element to be presented after the next edge.
   assign rq_din    = capture ? result_data[0] : buf_q[nxt_idx];
   assign rq_relu   = capture ? relu_en : relu_q;

   requant_unit #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .din     (rq_din),
      .relu_en (rq_relu),
      .dout    (rq_dout),
      .sat     (rq_sat)
   );

   // Frame buffer carries no reset: its contents only matter after a capture.
   generate
      for (genvar gi = 0; gi < NUM_RESULTS; gi++) begin : g_buf
         assign buf_d[gi] = capture ? result_data[gi] : buf_q[gi];
         always_ff @(posedge clk) begin
            buf_q[gi] <= buf_d[gi];
         end
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_sat_d   = out_sat_q;
      relu_d      = relu_q;
      sat_d       = sat_q;
      drop_d      = drop_q;

      if (capture) begin
         state_d     = ST_STREAM;
         idx_d       = '0;
         sat_d       = '0;
         relu_d      = relu_en;
         out_valid_d = 1'b1;
         out_data_d  = rq_dout;
         out_sat_d   = rq_sat;
         out_last_d  = (NUM_RESULTS == 1);
      end else if (xfer) begin
         sat_d = sat_q + {{(SAT_W-1){1'b0}}, out_sat_q};
         if (out_last_q) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end else begin
            idx_d      = nxt_idx;
            out_data_d = rq_dout;
            out_sat_d  = rq_sat;
            out_last_d = (nxt_idx == IDX_W'(NUM_RESULTS - 1));
         end
      end

      if (done_signal && !capture) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_sat_q   <= 1'b0;
         relu_q      <= 1'b0;
         sat_q       <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_sat_q   <= out_sat_d;
         relu_q      <= relu_d;
         sat_q       <= sat_d;
         drop_q      <= drop_d;
      end
   end

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_data_q;
   assign out_if.out_index = idx_q;
   assign out_if.out_last  = out_last_q;
   assign busy             = (state_q == ST_STREAM);
   assign sat_count        = sat_q;
   assign drop_err         = drop_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed self-checking bench for conv_result_streamer: requantisation, backpressure,
// back-to-back and dropped frames, and asynchronous reset mid-stream.
module tb_conv_result_streamer;

   localparam int N     = 30;
   localparam int IDX_W = 5;
   localparam int SAT_W = 5;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                done_signal = 1'b0;
   logic                relu_en = 1'b0;
   logic signed [17:0]  result_data [0:N-1];
   logic                busy;
   logic [SAT_W-1:0]    sat_count;
   logic                drop_err;

   int                  checks = 0;
   int                  failures = 0;
   int                  exp_data [0:N-1];
   logic signed [17:0]  next_data [0:N-1];
   logic                next_relu = 1'b0;

   conv_result_streamer_if #(.OUT_W(8), .IDX_W(IDX_W)) sif ();

   conv_result_streamer #(
      .NUM_RESULTS (N),
      .IN_W        (18),
      .OUT_W       (8),
      .SHIFT       (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .done_signal (done_signal),
      .result_data (result_data),
      .relu_en     (relu_en),
      .busy        (busy),
      .sat_count   (sat_count),
      .drop_err    (drop_err),
      .out_if      (sif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " out_valid"}, 32'(sif.out_valid), 0);
      check({tag, " out_data"},  32'(sif.out_data), 0);
      check({tag, " out_index"}, 32'(sif.out_index), 0);
      check({tag, " out_last"},  32'(sif.out_last), 0);
      check({tag, " sat_count"}, 32'(sat_count), 0);
      check({tag, " drop_err"},  32'(drop_err), 0);
      check({tag, " busy"},      32'(busy), 0);
   endtask

   // Called on a falling edge; the capture happens on the following rising edge.
   task automatic pulse_done();
      done_signal = 1'b1;
      @(negedge clk);
      done_signal = 1'b0;
   endtask

   // Consumes one frame against exp_data, starting at the falling edge right after capture.
   task automatic run_stream(input string tag, input bit rnd, input bit b2b, input int drop_at);
      int              got;
      int              cyc;
      bit              stalled;
      bit              dropped;
      bit              rdy;
      logic signed [7:0] h_data;
      logic [IDX_W-1:0]  h_idx;
      logic              h_last;
      got = 0; cyc = 0; stalled = 0; dropped = 0;
      h_data = '0; h_idx = '0; h_last = 1'b0;
      check({tag, " entry valid"}, 32'(sif.out_valid), 1);
      check({tag, " entry index"}, 32'(sif.out_index), 0);
      while (got < N) begin
         if (cyc >= 1000) begin
            check({tag, " timeout elements"}, got, N);
            break;
         end
         if (stalled) begin
            check({tag, " hold valid"}, 32'(sif.out_valid), 1);
            check({tag, " hold data"},  32'(sif.out_data), 32'(h_data));
            check({tag, " hold index"}, 32'(sif.out_index), 32'(h_idx));
            check({tag, " hold last"},  32'(sif.out_last), 32'(h_last));
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rnd) relu_en = 1'($urandom_range(0, 1));
         sif.out_ready = rdy;
         if (drop_at >= 0 && !dropped && sif.out_valid && int'(sif.out_index) == drop_at) begin
            done_signal = 1'b1;
            dropped = 1'b1;
            for (int i = 0; i < N; i++) result_data[i] = 18'sd1000;
         end
         if (sif.out_valid && rdy) begin
            $display("%s xfer index=%0d data=%0d last=%0d", tag, sif.out_index, sif.out_data, sif.out_last);
            check({tag, " index"}, 32'(sif.out_index), got);
            check({tag, " data"},  32'(sif.out_data), exp_data[got]);
            check({tag, " last"},  32'(sif.out_last), (got == N - 1) ? 1 : 0);
            got++;
            if (got == N && b2b) begin
               result_data = next_data;
               relu_en = next_relu;
               done_signal = 1'b1;
            end
         end
         stalled = sif.out_valid && !rdy;
         h_data = sif.out_data;
         h_idx  = sif.out_index;
         h_last = sif.out_last;
         @(negedge clk);
         cyc++;
         done_signal = 1'b0;
      end
   endtask

   task automatic load_ramp();
      for (int i = 0; i < N; i++) begin
         result_data[i] = 18'(i * 4 - 60);
         exp_data[i]    = i - 15;
      end
   endtask

   initial begin
      sif.out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         result_data[i] = '0;
         next_data[i]   = '0;
         exp_data[i]    = 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // Basic requantisation: (4i-60)>>>2 = i-15
      load_ramp();
      relu_en = 1'b0;
      pulse_done();
      run_stream("basic", 1'b0, 1'b0, -1);
      check("basic busy after", 32'(busy), 0);
      check("basic valid after", 32'(sif.out_valid), 0);
      check("basic sat_count", 32'(sat_count), 0);

      // Saturation without ReLU
      for (int i = 0; i < N; i++) begin
         result_data[i] = '0;
         exp_data[i]    = 0;
      end
      result_data[0] = 18'sd1000;  result_data[1] = -18'sd1000; result_data[2] = -18'sd1;
      result_data[3] = 18'sd100;   result_data[4] = -18'sd100;
      exp_data[0] = 127; exp_data[1] = -128; exp_data[2] = -1; exp_data[3] = 25; exp_data[4] = -25;
      relu_en = 1'b0;
      pulse_done();
      run_stream("sat", 1'b0, 1'b0, -1);
      check("sat sat_count", 32'(sat_count), 2);

      // Saturation with ReLU: clamping to zero is not a saturation
      exp_data[0] = 127; exp_data[1] = 0; exp_data[2] = 0; exp_data[3] = 25; exp_data[4] = 0;
      relu_en = 1'b1;
      pulse_done();
      relu_en = 1'b0;
      run_stream("relu", 1'b0, 1'b0, -1);
      check("relu sat_count", 32'(sat_count), 1);

      // Backpressure with relu_en toggling mid-frame: (8i-100)>>>2 = 2i-25
      for (int i = 0; i < N; i++) begin
         result_data[i] = 18'(i * 8 - 100);
         exp_data[i]    = 2 * i - 25;
      end
      relu_en = 1'b0;
      pulse_done();
      run_stream("bp", 1'b1, 1'b0, -1);
      relu_en = 1'b0;
      check("bp sat_count", 32'(sat_count), 0);
      check("bp busy after", 32'(busy), 0);

      // Back-to-back: frame B (600-40i)>>>2 = 150-10i, saturating at i=0,1,2,28,29
      load_ramp();
      for (int i = 0; i < N; i++) next_data[i] = 18'(600 - 40 * i);
      next_relu = 1'b0;
      pulse_done();
      run_stream("b2bA", 1'b0, 1'b1, -1);
      for (int i = 0; i < N; i++) begin
         exp_data[i] = 150 - 10 * i;
         if (exp_data[i] > 127)  exp_data[i] = 127;
         if (exp_data[i] < -128) exp_data[i] = -128;
      end
      run_stream("b2bB", 1'b0, 1'b0, -1);
      check("b2b drop_err", 32'(drop_err), 0);
      check("b2b sat_count", 32'(sat_count), 5);

      // Dropped frame at index 10: stream continues with the original data
      load_ramp();
      pulse_done();
      run_stream("drop", 1'b0, 1'b0, 10);
      check("drop drop_err", 32'(drop_err), 1);
      check("drop busy after", 32'(busy), 0);

      // Asynchronous reset at index 7
      load_ramp();
      pulse_done();
      sif.out_ready = 1'b1;
      repeat (7) @(negedge clk);
      check("mid index before rst", 32'(sif.out_index), 7);
      check("mid valid before rst", 32'(sif.out_valid), 1);
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post-rst idle busy", 32'(busy), 0);

      load_ramp();
      pulse_done();
      run_stream("postrst", 1'b0, 1'b0, -1);
      check("postrst sat_count", 32'(sat_count), 0);
      check("postrst drop_err", 32'(drop_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Output-side counterpart of the 1-D convolution engine. It captures the engine's 30-entry signed 18-bit result vector on the engine's one-cycle `done_signal` pulse. Each result is requantised to signed 8-bit using an arithmetic shift, optional ReLU and saturation. The results are then streamed one per cycle over a valid/ready handshake to the next NPU stage (the row writer or the next layer's row packer).

## Interface
Parameters:
- NUM_RESULTS, 30, number of result entries per frame
- IN_W, 18, signed input result width
- OUT_W, 8, signed output width
- SHIFT, 2, arithmetic right shift applied before saturation (0..IN_W-1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- done_signal  in  1  one-cycle frame-complete pulse from the conv engine
- result_data  in  IN_W x NUM_RESULTS, signed, unpacked [0:NUM_RESULTS-1]; valid in the cycle done_signal is high
- relu_en  in  1  ReLU enable, sampled at capture
- busy  out  1  frame held or streaming
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W, signed, requantised result
- out_index  out  $clog2(NUM_RESULTS), index of the current element
- out_last  out  1  high with element NUM_RESULTS-1
- sat_count  out  $clog2(NUM_RESULTS+1), saturated elements in the current frame
- drop_err  out  1  sticky; set when a frame is lost

## Operation
- States: IDLE and STREAM.
- **Capture in IDLE:** when done_signal=1, all NUM_RESULTS entries are copied into a local buffer, relu_en is latched, the index goes to 0, sat_count goes to 0, and the state becomes STREAM.
- **Requantisation of element i:**
  - v = result[i] >>> SHIFT, arithmetic shift (floor toward -inf).
  - If latched relu_en=1 and v<0, then v=0.
  - Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- **Transfer:** a transfer occurs when out_valid && out_ready.
  - After each transfer the index increments.
  - sat_count increments once per transferred element that hit a saturation bound. ReLU clamping is not counted.
- **Last transfer:** the transfer with out_last=1 ends the frame and the state returns to IDLE.
- **Back-to-back frames:** done_signal in the same cycle as the last transfer is captured. The state stays STREAM and element 0 of the new frame is presented next cycle. sat_count restarts at 0.
- **Lost frame:** done_signal in STREAM, other than on the last-transfer cycle, is ignored. drop_err is set and stays set until reset.
- busy = (state==STREAM).

## Timing
- Reset values:
  - state IDLE, out_valid 0, out_data 0, out_index 0, out_last 0, sat_count 0, drop_err 0, busy 0.
  - Buffer contents don't-care.
- Latency: done_signal sampled at edge N gives out_valid=1 with element 0 after edge N (registered output, one cycle).
- Throughput: one element per cycle while out_ready=1. A full frame takes NUM_RESULTS cycles with no bubbles.
- While out_valid && !out_ready, out_data, out_index and out_last hold stable. out_valid never drops before its transfer.
- out_valid deasserts the cycle after the last transfer, unless a frame was captured on that cycle.
- rst asserted mid-stream aborts the frame immediately, with all outputs at their reset values. The first done_signal after release starts a clean frame.
- out_ready is ignored when out_valid=0.

## Structure
- Shared package `npu_pkg`:
  - RESULT_W=18, PIXEL_W=8, NUM_RESULTS=30.
  - State enum `stream_state_t {ST_IDLE, ST_STREAM}`.
- One sub-module, `requant_unit`: combinational shift, ReLU and saturate, with an output saturation flag. It is reused later by other layers.
- Output stage is registered. out_data comes from a register, not from a combinational path through the buffer.

## Test plan
- **Basic requantisation:** relu_en=0, result[i]=i*4-60, done pulse, out_ready=1.
  - Expect out_data = i-15 for i=0..29.
  - Expect out_last only at index 29, sat_count=0, busy low the cycle after the last transfer.
- **Saturation and ReLU:** results {1000,-1000,-1,100,-100} in entries 0..4.
  - relu_en=0: expect {127,-128,-1,25,-25} and sat_count=2.
  - relu_en=1: expect {127,0,0,25,0} and sat_count=1.
- **Backpressure:** toggle out_ready pseudo-randomly.
  - Data, index and last stay stable while stalled; every element is delivered exactly once, in order.
  - relu_en changes mid-frame have no effect.
- **Back-to-back frames:** second done_signal on the last-transfer cycle.
  - Frame-2 element 0 appears next cycle, out_valid never drops, drop_err stays 0.
- **Dropped frame:** done_signal at index 10.
  - Frame-1 data continues unchanged and drop_err becomes 1.
- **Reset mid-stream:** drive rst=0 at index 7.
  - All outputs reset asynchronously.
  - A fresh frame after release streams correctly from index 0.
